// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU and mul/div opcodes, branch
// funct3 values, forwarding selects and the divider state type.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/serial_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle, with
// signed/unsigned quotient and remainder and the RISC-V special cases.
module serial_divider
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             advance,
  input  logic             is_signed,
  input  logic             is_rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // Handshake: start is level-held by the owner while the op sits in EX.
  // busy is high from the first cycle start is seen in IDLE until the result
  // is ready; done marks a valid result, held until advance (or abort) is seen.
  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       state_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             negq_q, negr_q, sel_rem_q;

  logic             a_neg, b_neg, div0, ovf, take;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign div0  = (b == '0);
  assign ovf   = is_signed & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);

  // rem_q < divisor always holds, so a clear top bit of diff means no borrow.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign take    = ~diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      sel_rem_q <= 1'b0;
    end else if (abort) begin
      state_q <= DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            sel_rem_q <= is_rem;
            if (div0) begin
              quo_q   <= '1;
              rem_q   <= a;
              negq_q  <= 1'b0;
              negr_q  <= 1'b0;
              state_q <= DIV_DONE;
            end else if (ovf) begin
              quo_q   <= a;
              rem_q   <= '0;
              negq_q  <= 1'b0;
              negr_q  <= 1'b0;
              state_q <= DIV_DONE;
            end else begin
              quo_q   <= a_mag;
              rem_q   <= '0;
              dvs_q   <= b_mag;
              negq_q  <= a_neg ^ b_neg;
              negr_q  <= a_neg;
              cnt_q   <= CW'(WIDTH);
              state_q <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          rem_q <= take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], take};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= DIV_DONE;
        end
        DIV_DONE: begin
          if (advance) state_q <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign busy   = ((state_q == DIV_IDLE) & start) | (state_q == DIV_RUN);
  assign done   = (state_q == DIV_DONE);
  assign result = sel_rem_q ? (negr_q ? -rem_q : rem_q)
                            : (negq_q ? -quo_q : quo_q);

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: ID/EX register, forwarding, ALU, branch resolution,
// single-cycle multiplier and a stalling serial divider.
module execute_stage
  import exec_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REGW   = 5,
  parameter int MULDIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             JalrD,
  input  logic             ALUSrcAD,
  input  logic             ALUSrcBD,
  input  logic             MulDivD,
  input  logic [1:0]       ResultSrcD,
  input  logic [3:0]       ALUControlD,
  input  logic [2:0]       Funct3D,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] PCD,
  input  logic [WIDTH-1:0] ImmExtD,
  input  logic [WIDTH-1:0] PCPlus4D,
  input  logic [REGW-1:0]  Rs1D,
  input  logic [REGW-1:0]  Rs2D,
  input  logic [REGW-1:0]  RdD,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [WIDTH-1:0] ALUResultM,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic [1:0]       ResultSrcE,
  output logic             PCSrcE,
  output logic             BusyE,
  output logic [WIDTH-1:0] ALUResultE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic [WIDTH-1:0] PCPlus4E,
  output logic [REGW-1:0]  Rs1E,
  output logic [REGW-1:0]  Rs2E,
  output logic [REGW-1:0]  RdE
);

  localparam int SHW = $clog2(WIDTH);

  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             jump;
    logic             branch;
    logic             jalr;
    logic             src_a;
    logic             src_b;
    logic             muldiv;
    logic [1:0]       result_src;
    logic [3:0]       alu_ctrl;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc_plus4;
    logic [REGW-1:0]  rs1;
    logic [REGW-1:0]  rs2;
    logic [REGW-1:0]  rd;
  } idex_t;

  idex_t idex_q, idex_d;

  always_comb begin
    idex_d            = '0;
    idex_d.reg_write  = RegWriteD;
    idex_d.mem_write  = MemWriteD;
    idex_d.jump       = JumpD;
    idex_d.branch     = BranchD;
    idex_d.jalr       = JalrD;
    idex_d.src_a      = ALUSrcAD;
    idex_d.src_b      = ALUSrcBD;
    idex_d.muldiv     = MulDivD & (MULDIV != 0);
    idex_d.result_src = ResultSrcD;
    idex_d.alu_ctrl   = ALUControlD;
    idex_d.funct3     = Funct3D;
    idex_d.rd1        = RD1D;
    idex_d.rd2        = RD2D;
    idex_d.pc         = PCD;
    idex_d.imm        = ImmExtD;
    idex_d.pc_plus4   = PCPlus4D;
    idex_d.rs1        = Rs1D;
    idex_d.rs2        = Rs2D;
    idex_d.rd         = RdD;
  end

  // A bubble clears the data fields too, so a flushed slot shows all-zero outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  idex_q <= '0;
    else if (FlushE)             idex_q <= '0;
    else if (!(StallE || BusyE)) idex_q <= idex_d;
  end

  logic [WIDTH-1:0] fwd_a, fwd_b, src_a, src_b, alu_res, jalr_sum;
  logic [SHW-1:0]   shamt;
  logic             taken;

  always_comb begin
    case (ForwardAE)
      FWD_WB:  fwd_a = ResultW;
      FWD_MEM: fwd_a = ALUResultM;
      default: fwd_a = idex_q.rd1;
    endcase
    case (ForwardBE)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALUResultM;
      default: fwd_b = idex_q.rd2;
    endcase
  end

  assign src_a = idex_q.src_a ? idex_q.pc : fwd_a;
  assign src_b = idex_q.src_b ? idex_q.imm : fwd_b;
  assign shamt = src_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (idex_q.alu_ctrl)
      ALU_ADD:   alu_res = src_a + src_b;
      ALU_SUB:   alu_res = src_a - src_b;
      ALU_AND:   alu_res = src_a & src_b;
      ALU_OR:    alu_res = src_a | src_b;
      ALU_XOR:   alu_res = src_a ^ src_b;
      ALU_SLL:   alu_res = src_a << shamt;
      ALU_SRL:   alu_res = src_a >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(src_a) >>> shamt);
      ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      ALU_PASSB: alu_res = src_b;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (idex_q.funct3)
      F3_BEQ:  taken = (fwd_a == fwd_b);
      F3_BNE:  taken = (fwd_a != fwd_b);
      F3_BLT:  taken = ($signed(fwd_a) < $signed(fwd_b));
      F3_BGE:  taken = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: taken = (fwd_a < fwd_b);
      F3_BGEU: taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum  = fwd_a + idex_q.imm;
  assign PCSrcE    = idex_q.jump | (idex_q.branch & taken);
  assign PCTargetE = idex_q.jalr ? {jalr_sum[WIDTH-1:1], 1'b0} : idex_q.pc + idex_q.imm;

  // One 2W-bit product serves all four multiply ops via operand extension.
  logic             a_sgn, b_sgn;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;

  assign a_sgn = (idex_q.funct3 == MD_MULH) | (idex_q.funct3 == MD_MULHSU);
  assign b_sgn = (idex_q.funct3 == MD_MULH);
  assign mul_a = {{WIDTH{src_a[WIDTH-1] & a_sgn}}, src_a};
  assign mul_b = {{WIDTH{src_b[WIDTH-1] & b_sgn}}, src_b};
  assign prod  = mul_a * mul_b;

  logic             muldiv_en, div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_result;

  assign muldiv_en = (MULDIV != 0) & idex_q.muldiv;
  assign div_start = muldiv_en & idex_q.funct3[2];

  serial_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (FlushE),
    .advance   (~StallE),
    .is_signed (~idex_q.funct3[0]),
    .is_rem    (idex_q.funct3[1]),
    .a         (src_a),
    .b         (src_b),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  assign BusyE = (MULDIV != 0) & div_busy;

  always_comb begin
    if (!muldiv_en)                     ALUResultE = alu_res;
    else if (idex_q.funct3[2])          ALUResultE = div_done ? div_result : '0;
    else if (idex_q.funct3 == MD_MUL)   ALUResultE = prod[WIDTH-1:0];
    else                                ALUResultE = prod[2*WIDTH-1:WIDTH];
  end

  assign RegWriteE  = idex_q.reg_write;
  assign MemWriteE  = idex_q.mem_write;
  assign ResultSrcE = idex_q.result_src;
  assign WriteDataE = fwd_b;
  assign PCPlus4E   = idex_q.pc_plus4;
  assign Rs1E       = idex_q.rs1;
  assign Rs2E       = idex_q.rs2;
  assign RdE        = idex_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table for single-cycle ops plus
// hand sequences for reset, flush, stall and the serial divider.
module tb_execute_stage;
  import exec_pkg::*;

  logic        clk, rst_n, StallE, FlushE;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, JalrD, ALUSrcAD, ALUSrcBD, MulDivD;
  logic [1:0]  ResultSrcD;
  logic [3:0]  ALUControlD;
  logic [2:0]  Funct3D;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW, ALUResultM;
  logic        RegWriteE, MemWriteE, PCSrcE, BusyE;
  logic [1:0]  ResultSrcE;
  logic [31:0] ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  execute_stage #(.WIDTH(32), .REGW(5), .MULDIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .JalrD(JalrD), .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .MulDivD(MulDivD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .Funct3D(Funct3D),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW), .ALUResultM(ALUResultM),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .BusyE(BusyE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // control-bit packing {srcA, srcB, branch, jump, jalr, muldiv}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_MD   = 6'b000001;
  localparam logic [5:0] C_JALR = 6'b000010;
  localparam logic [5:0] C_JMP  = 6'b000100;
  localparam logic [5:0] C_BR   = 6'b001000;
  localparam logic [5:0] C_SB   = 6'b010000;
  localparam logic [5:0] C_SA   = 6'b100000;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic [5:0]  ctl;
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, pc, imm, resw, alum;
    logic [31:0] e_alu;
    logic        e_pcsrc;
    logic [31:0] e_tgt, e_wd;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input string n, input logic [3:0] op, input logic [2:0] f3,
                              input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [31:0] resw, input logic [31:0] alum,
                              input logic [31:0] e_alu, input logic e_pcsrc, input logic [31:0] e_tgt,
                              input logic [31:0] e_wd);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.ctl = ctl; v.fa = fa; v.fb = fb;
    v.rd1 = rd1; v.rd2 = rd2; v.pc = pc; v.imm = imm; v.resw = resw; v.alum = alum;
    v.e_alu = e_alu; v.e_pcsrc = e_pcsrc; v.e_tgt = e_tgt; v.e_wd = e_wd;
    return v;
  endfunction

  // scoreboard check
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drivers
  task automatic set_d(input logic [3:0] op, input logic [2:0] f3, input logic [5:0] ctl,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] pc, input logic [31:0] imm);
    {ALUSrcAD, ALUSrcBD, BranchD, JumpD, JalrD, MulDivD} = ctl;
    ALUControlD = op; Funct3D = f3;
    RD1D = rd1; RD2D = rd2; PCD = pc; ImmExtD = imm; PCPlus4D = pc + 32'd4;
    RegWriteD = 1'b1; MemWriteD = 1'b0; ResultSrcD = 2'b00;
    Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = '0; ALUResultM = '0;
  endtask

  task automatic nop_d();
    set_d(ALU_ADD, 3'd0, C_NONE, '0, '0, '0, '0);
    RegWriteD = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one divide; the next call enters on the edge ending DONE.
  task automatic div_run(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_busy);
    int cnt;
    set_d(ALU_ADD, f3, C_MD, a, b, 32'h100, '0);
    tick();
    nop_d();
    cnt = 0;
    while (BusyE && cnt < 100) begin
      cnt++;
      tick();
    end
    chk({name, "_busy_cycles"}, cnt, exp_busy);
    chk({name, "_result"}, ALUResultE, exp_res);
  endtask

  initial begin
    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    set_d(ALU_ADD, 3'd0, C_NONE, 32'd3, 32'd4, 32'h100, 32'h8);
    MemWriteD = 1'b1; ResultSrcD = 2'b01;

    // reset: every output 0
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_regwrite", RegWriteE, 0);
    chk("rst_memwrite", MemWriteE, 0);
    chk("rst_resultsrc", ResultSrcE, 0);
    chk("rst_pcsrc", PCSrcE, 0);
    chk("rst_busy", BusyE, 0);
    chk("rst_alu", ALUResultE, 0);
    chk("rst_wdata", WriteDataE, 0);
    chk("rst_target", PCTargetE, 0);
    chk("rst_pcplus4", PCPlus4E, 0);
    chk("rst_rd", {Rs1E, Rs2E, RdE}, 0);

    // flush on first cycle after reset
    rst_n = 1'b1;
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    chk("flush_regwrite", RegWriteE, 0);
    chk("flush_memwrite", MemWriteE, 0);
    chk("flush_alu", ALUResultE, 0);
    chk("flush_pcplus4", PCPlus4E, 0);
    chk("flush_rd", RdE, 0);

    // normal load
    tick();
    chk("load_regwrite", RegWriteE, 1);
    chk("load_memwrite", MemWriteE, 1);
    chk("load_resultsrc", ResultSrcE, 2'b01);
    chk("load_alu", ALUResultE, 32'd7);
    chk("load_target", PCTargetE, 32'h108);
    chk("load_pcplus4", PCPlus4E, 32'h104);
    chk("load_regs", {Rs1E, Rs2E, RdE}, {17'd0, 5'd1, 5'd2, 5'd3});

    // stall holds ID/EX; flush overrides stall
    StallE = 1'b1;
    set_d(ALU_ADD, 3'd0, C_NONE, 32'd10, 32'd10, 32'h200, '0);
    tick();
    chk("stall_hold_alu", ALUResultE, 32'd7);
    chk("stall_hold_pcplus4", PCPlus4E, 32'h104);
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0; StallE = 1'b0;
    chk("flush_over_stall", RegWriteE, 0);
    tick();
    chk("after_stall_alu", ALUResultE, 32'd20);

    // single-cycle vector table
    vecs.push_back(mk("addi_fwd_mem", ALU_ADD, 3'd0, C_SB, 2'b10, 2'b00, 32'h5, 32'h0, 32'h100, 32'h3, 32'h0, 32'h10, 32'h13, 1'b0, 32'h103, 32'h0));
    vecs.push_back(mk("addi_fwd_wb", ALU_ADD, 3'd0, C_SB, 2'b01, 2'b00, 32'h5, 32'h0, 32'h100, 32'h3, 32'h7, 32'h10, 32'hA, 1'b0, 32'h103, 32'h0));
    vecs.push_back(mk("addi_fwd_rsvd", ALU_ADD, 3'd0, C_SB, 2'b11, 2'b00, 32'h20, 32'h0, 32'h100, 32'h1, 32'h77, 32'h99, 32'h21, 1'b0, 32'h101, 32'h0));
    vecs.push_back(mk("sub", ALU_SUB, 3'd0, C_NONE, 2'b00, 2'b00, 32'd10, 32'd3, 32'h100, 32'h0, 32'h0, 32'h0, 32'd7, 1'b0, 32'h100, 32'd3));
    vecs.push_back(mk("sub_fwdb_mem", ALU_SUB, 3'd0, C_NONE, 2'b00, 2'b10, 32'd10, 32'd3, 32'h100, 32'h0, 32'h0, 32'd2, 32'd8, 1'b0, 32'h100, 32'd2));
    vecs.push_back(mk("sub_fwdb_wb", ALU_SUB, 3'd0, C_NONE, 2'b00, 2'b01, 32'd10, 32'd3, 32'h100, 32'h0, 32'd4, 32'h0, 32'd6, 1'b0, 32'h100, 32'd4));
    vecs.push_back(mk("and", ALU_AND, 3'd0, C_NONE, 2'b00, 2'b00, 32'hF0F0, 32'hFF00, 32'h100, 32'h0, 32'h0, 32'h0, 32'hF000, 1'b0, 32'h100, 32'hFF00));
    vecs.push_back(mk("or", ALU_OR, 3'd0, C_NONE, 2'b00, 2'b00, 32'hF0, 32'h0F, 32'h100, 32'h0, 32'h0, 32'h0, 32'hFF, 1'b0, 32'h100, 32'h0F));
    vecs.push_back(mk("xor", ALU_XOR, 3'd0, C_NONE, 2'b00, 2'b00, 32'hFF, 32'h0F, 32'h100, 32'h0, 32'h0, 32'h0, 32'hF0, 1'b0, 32'h100, 32'h0F));
    vecs.push_back(mk("sll_wrap", ALU_SLL, 3'd0, C_NONE, 2'b00, 2'b00, 32'h1, 32'h24, 32'h100, 32'h0, 32'h0, 32'h0, 32'h10, 1'b0, 32'h100, 32'h24));
    vecs.push_back(mk("srl", ALU_SRL, 3'd0, C_NONE, 2'b00, 2'b00, 32'h80000000, 32'h4, 32'h100, 32'h0, 32'h0, 32'h0, 32'h08000000, 1'b0, 32'h100, 32'h4));
    vecs.push_back(mk("sra", ALU_SRA, 3'd0, C_NONE, 2'b00, 2'b00, 32'h80000000, 32'h4, 32'h100, 32'h0, 32'h0, 32'h0, 32'hF8000000, 1'b0, 32'h100, 32'h4));
    vecs.push_back(mk("slt", ALU_SLT, 3'd0, C_NONE, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h0, 32'h0, 32'h0, 32'h1, 1'b0, 32'h100, 32'h1));
    vecs.push_back(mk("sltu", ALU_SLTU, 3'd0, C_NONE, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h100, 32'h1));
    vecs.push_back(mk("lui", ALU_PASSB, 3'd0, C_SB, 2'b00, 2'b00, 32'h55, 32'h0, 32'h100, 32'h12345000, 32'h0, 32'h0, 32'h12345000, 1'b0, 32'h12345100, 32'h0));
    vecs.push_back(mk("auipc", ALU_ADD, 3'd0, C_SA | C_SB, 2'b00, 2'b00, 32'h55, 32'h0, 32'h1000, 32'h2000, 32'h0, 32'h0, 32'h3000, 1'b0, 32'h3000, 32'h0));
    vecs.push_back(mk("blt", ALU_SUB, 3'b100, C_BR, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b1, 32'h210, 32'h1));
    vecs.push_back(mk("bltu", ALU_SUB, 3'b110, C_BR, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 32'h210, 32'h1));
    vecs.push_back(mk("bge", ALU_SUB, 3'b101, C_BR, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 32'h210, 32'h1));
    vecs.push_back(mk("bgeu", ALU_SUB, 3'b111, C_BR, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b1, 32'h210, 32'h1));
    vecs.push_back(mk("beq", ALU_SUB, 3'b000, C_BR, 2'b00, 2'b00, 32'h5, 32'h5, 32'h200, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, 32'h210, 32'h5));
    vecs.push_back(mk("bne", ALU_SUB, 3'b001, C_BR, 2'b00, 2'b00, 32'h5, 32'h5, 32'h200, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 32'h210, 32'h5));
    vecs.push_back(mk("b_f3_010", ALU_SUB, 3'b010, C_BR, 2'b00, 2'b00, 32'h5, 32'h5, 32'h200, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 32'h210, 32'h5));
    vecs.push_back(mk("beq_ne", ALU_SUB, 3'b000, C_BR, 2'b00, 2'b00, 32'h5, 32'h6, 32'h200, 32'h10, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h210, 32'h6));
    vecs.push_back(mk("beq_fwd", ALU_SUB, 3'b000, C_BR, 2'b10, 2'b00, 32'h0, 32'h9, 32'h200, 32'h10, 32'h0, 32'h9, 32'h0, 1'b1, 32'h210, 32'h9));
    vecs.push_back(mk("jalr", ALU_ADD, 3'd0, C_SB | C_JMP | C_JALR, 2'b00, 2'b00, 32'h1001, 32'h0, 32'h300, 32'h4, 32'h0, 32'h0, 32'h1005, 1'b1, 32'h1004, 32'h0));
    vecs.push_back(mk("jalr_fwd", ALU_ADD, 3'd0, C_SB | C_JMP | C_JALR, 2'b01, 2'b00, 32'h1001, 32'h0, 32'h300, 32'h10, 32'h2003, 32'h0, 32'h2013, 1'b1, 32'h2012, 32'h0));
    vecs.push_back(mk("jal", ALU_ADD, 3'd0, C_JMP, 2'b00, 2'b00, 32'h0, 32'h0, 32'h400, 32'h20, 32'h0, 32'h0, 32'h0, 1'b1, 32'h420, 32'h0));
    vecs.push_back(mk("mul", ALU_ADD, 3'b000, C_MD, 2'b00, 2'b00, 32'hFFFFFFFD, 32'h5, 32'h100, 32'h0, 32'h0, 32'h0, 32'hFFFFFFF1, 1'b0, 32'h100, 32'h5));
    vecs.push_back(mk("mulh", ALU_ADD, 3'b001, C_MD, 2'b00, 2'b00, 32'hFFFFFFFD, 32'h5, 32'h100, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h100, 32'h5));
    vecs.push_back(mk("mulh_min", ALU_ADD, 3'b001, C_MD, 2'b00, 2'b00, 32'h80000000, 32'h80000000, 32'h100, 32'h0, 32'h0, 32'h0, 32'h40000000, 1'b0, 32'h100, 32'h80000000));
    vecs.push_back(mk("mulhu", ALU_ADD, 3'b011, C_MD, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h100, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 32'h100, 32'hFFFFFFFF));
    vecs.push_back(mk("mulhsu", ALU_ADD, 3'b010, C_MD, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h100, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h100, 32'hFFFFFFFF));
    vecs.push_back(mk("mulhsu_pos", ALU_ADD, 3'b010, C_MD, 2'b00, 2'b00, 32'h2, 32'hFFFFFFFF, 32'h100, 32'h0, 32'h0, 32'h0, 32'h1, 1'b0, 32'h100, 32'hFFFFFFFF));
    vecs.push_back(mk("mulh_neg1", ALU_ADD, 3'b001, C_MD, 2'b00, 2'b00, 32'h2, 32'hFFFFFFFF, 32'h100, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h100, 32'hFFFFFFFF));
    vecs.push_back(mk("mulhu_pos", ALU_ADD, 3'b011, C_MD, 2'b00, 2'b00, 32'h2, 32'hFFFFFFFF, 32'h100, 32'h0, 32'h0, 32'h0, 32'h1, 1'b0, 32'h100, 32'hFFFFFFFF));

    foreach (vecs[i]) begin
      set_d(vecs[i].op, vecs[i].f3, vecs[i].ctl, vecs[i].rd1, vecs[i].rd2, vecs[i].pc, vecs[i].imm);
      ForwardAE = vecs[i].fa; ForwardBE = vecs[i].fb;
      ResultW = vecs[i].resw; ALUResultM = vecs[i].alum;
      tick();
      chk({vecs[i].name, "_alu"}, ALUResultE, vecs[i].e_alu);
      chk({vecs[i].name, "_pcsrc"}, PCSrcE, vecs[i].e_pcsrc);
      chk({vecs[i].name, "_target"}, PCTargetE, vecs[i].e_tgt);
      chk({vecs[i].name, "_wdata"}, WriteDataE, vecs[i].e_wd);
      chk({vecs[i].name, "_busy"}, BusyE, 0);
      chk({vecs[i].name, "_regwrite"}, RegWriteE, 1);
    end

    // divides, issued back to back
    div_run("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    div_run("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    div_run("divu_by0", 3'b101, 32'h1234, 32'd0, 32'hFFFFFFFF, 1);
    div_run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    div_run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    div_run("remu_by0", 3'b111, 32'd7, 32'd0, 32'd7, 1);
    div_run("rem_by0_neg", 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1);
    div_run("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    div_run("remu_big", 3'b111, 32'hFFFFFFFF, 32'h10, 32'hF, 33);
    div_run("div_7_m2", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    div_run("rem_7_m2", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    tick();
    chk("div_drain_busy", BusyE, 0);

    // abort at RUN cycle 10, then a normal ADD
    set_d(ALU_ADD, 3'b100, C_MD, 32'hFFFFFFF9, 32'd2, 32'h100, '0);
    tick();
    chk("abort_entry_busy", BusyE, 1);
    nop_d();
    repeat (10) tick();
    chk("abort_run10_busy", BusyE, 1);
    set_d(ALU_ADD, 3'd0, C_NONE, 32'd2, 32'd3, 32'h100, '0);
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    chk("abort_busy_drop", BusyE, 0);
    chk("abort_bubble_regwrite", RegWriteE, 0);
    tick();
    chk("abort_next_add", ALUResultE, 32'd5);
    chk("abort_next_busy", BusyE, 0);
    chk("abort_next_regwrite", RegWriteE, 1);

    // stall held in DONE: result stable, no restart
    div_run("div_stall", 3'b100, 32'd100, 32'd7, 32'd14, 33);
    StallE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("done_stall_busy", BusyE, 0);
      chk("done_stall_result", ALUResultE, 32'd14);
    end
    StallE = 1'b0;
    tick();
    chk("done_release_busy", BusyE, 0);
    chk("done_release_alu", ALUResultE, 32'd0);
    tick();
    chk("done_release_idle", BusyE, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
